cnn_pool2d: RTL and testbench

Parametrised streaming 2-D pooling stage for the CNN pipeline; sits between the ReLU output and the channel accumulator (`cnn_acc_ci`). Consumes one raster-ordered pixel (all CI channels) per valid cycle and emits one pooled pixel per completed POOL_K×POOL_K window, with stride = POOL_K. Generalises the fixed 2×2 max pool to arbitrary image size, channel count and window size, and adds end-of-frame marking plus optional average mode.

---
 rtl/cnn_pool_pkg.sv | 41 ++++
 rtl/pool_lane.sv | 33 +++
 rtl/cnn_pool2d.sv | 194 +++++++++++++++++++
 tb/tb_cnn_pool2d.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pool_pkg.sv
// ============================================================================
// Module      : cnn_pool_pkg
// Description : Shared defaults, mode encodings and width helpers for the
//               streaming 2-D pooling stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pool_pkg;

  localparam int DEF_CI     = 3;
  localparam int DEF_IF_BW  = 8;
  localparam int DEF_IMG_W  = 8;
  localparam int DEF_IMG_H  = 8;
  localparam int DEF_POOL_K = 2;

  typedef enum logic [0:0] {
    MODE_MAX = 1'b0,
    MODE_AVG = 1'b1
  } pool_mode_e;

  function automatic int out_dim(input int n, input int k);
    return n / k;
  endfunction

  // An average window sums K*K samples, so it needs 2*log2(K) guard bits.
  function automatic int acc_bw(input int bw, input int k);
`ifdef POOL_AVG_EN
    return bw + 2 * $clog2(k);
`else
    return bw + 0 * k;
`endif
  endfunction

  function automatic int cnt_bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pool_lane.sv
// ============================================================================
// Module      : pool_lane
// Description : Single-channel reduce step: load, running max or running sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_lane
  import cnn_pool_pkg::*;
#(
  parameter int ACC_BW = 8
) (
  input  logic              i_mode,
  input  logic              i_load,
  input  logic [ACC_BW-1:0] i_acc,
  input  logic [ACC_BW-1:0] i_smp,
  output logic [ACC_BW-1:0] o_res
);

  always_comb begin
    o_res = i_smp;
    if (!i_load) begin
      if (i_mode == MODE_AVG) begin
        o_res = i_acc + i_smp;
      end else if (i_acc > i_smp) begin
        o_res = i_acc;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cnn_pool2d.sv
// ============================================================================
// Module      : cnn_pool2d
// Description : Streaming POOL_K x POOL_K pooling (stride POOL_K) over a raster
//               pixel stream. Define POOL_AVG_EN to add average mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_pool2d
  import cnn_pool_pkg::*;
#(
  parameter int CI     = DEF_CI,
  parameter int IF_BW  = DEF_IF_BW,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int POOL_K = DEF_POOL_K
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_in_valid,
  input  logic [CI*IF_BW-1:0] i_in_pixel,
  input  logic                i_mode,
  output logic                o_ot_valid,
  output logic [CI*IF_BW-1:0] o_ot_pool,
  output logic                o_ot_last
);

  localparam int OW     = out_dim(IMG_W, POOL_K);
  localparam int OH     = out_dim(IMG_H, POOL_K);
  localparam int ACC_BW = acc_bw(IF_BW, POOL_K);
  localparam int SH     = ACC_BW - IF_BW;
  localparam int COL_W  = cnt_bw(IMG_W);
  localparam int ROW_W  = cnt_bw(IMG_H);
  localparam int K_W    = cnt_bw(POOL_K);
  localparam int WC_W   = cnt_bw(OW);
  localparam int WR_W   = cnt_bw(OH);

  localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_H - 1);
  localparam logic [K_W-1:0]   c_k_last   = K_W'(POOL_K - 1);
  localparam logic [WC_W-1:0]  c_wc_last  = WC_W'(OW - 1);
  localparam logic [WR_W-1:0]  c_wr_last  = WR_W'(OH - 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [K_W-1:0]   r_wc_off;
  logic [K_W-1:0]   r_wr_off;
  logic [WC_W-1:0]  r_wc;
  logic [WR_W-1:0]  r_wr;
  logic             r_ctrail;
  logic             r_rtrail;

  logic [CI-1:0][ACC_BW-1:0] r_h;
  logic [CI-1:0][ACC_BW-1:0] r_p [0:OW-1];
  logic [CI-1:0][ACC_BW-1:0] w_h_nxt;
  logic [CI-1:0][ACC_BW-1:0] w_p_nxt;
  logic [CI-1:0][ACC_BW-1:0] w_p_cur;
  logic [CI*IF_BW-1:0]       w_pool;

  logic r_valid;
  logic r_last;
  logic [CI*IF_BW-1:0] r_pool;

  logic w_col_end;
  logic w_row_end;
  logic w_wc_end;
  logic w_wr_end;
  logic w_in_grid;
  logic w_done;
  logic w_mode;

  assign w_col_end = (r_col == c_col_last);
  assign w_row_end = (r_row == c_row_last);
  assign w_wc_end  = (r_wc_off == c_k_last);
  assign w_wr_end  = (r_wr_off == c_k_last);
  // The trailing flags mark columns/rows beyond the last full window.
  assign w_in_grid = !r_ctrail && !r_rtrail;
  assign w_done    = i_in_valid && w_wc_end && w_wr_end && w_in_grid;
  assign w_p_cur   = r_p[r_wc];

`ifdef POOL_AVG_EN
  logic r_mode_p [0:OW-1];
  logic w_win_start;

  assign w_win_start = (r_wc_off == '0) && (r_wr_off == '0);
  assign w_mode      = w_win_start ? i_mode : r_mode_p[r_wc];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < OW; i++) r_mode_p[i] <= MODE_MAX;
    end else if (i_in_valid && w_win_start && w_in_grid) begin
      r_mode_p[r_wc] <= i_mode;
    end
  end
`else
  // Max-only build: the mode pin is masked off so it never reaches the lanes.
  assign w_mode = i_mode & 1'b0;
`endif

  for (genvar c = 0; c < CI; c++) begin : g_lane
    pool_lane #(.ACC_BW(ACC_BW)) u_h_lane (
      .i_mode (w_mode),
      .i_load (r_wc_off == '0),
      .i_acc  (r_h[c]),
      .i_smp  (ACC_BW'(i_in_pixel[c*IF_BW +: IF_BW])),
      .o_res  (w_h_nxt[c])
    );

    pool_lane #(.ACC_BW(ACC_BW)) u_p_lane (
      .i_mode (w_mode),
      .i_load (r_wr_off == '0),
      .i_acc  (w_p_cur[c]),
      .i_smp  (w_h_nxt[c]),
      .o_res  (w_p_nxt[c])
    );

    assign w_pool[c*IF_BW +: IF_BW] = (w_mode == MODE_AVG) ?
                                      IF_BW'(w_p_nxt[c] >> SH) :
                                      w_p_nxt[c][IF_BW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_wc_off <= '0;
      r_wr_off <= '0;
      r_wc     <= '0;
      r_wr     <= '0;
      r_ctrail <= 1'b0;
      r_rtrail <= 1'b0;
    end else if (i_in_valid) begin
      if (w_col_end) begin
        r_col    <= '0;
        r_wc_off <= '0;
        r_wc     <= '0;
        r_ctrail <= 1'b0;
        if (w_row_end) begin
          r_row    <= '0;
          r_wr_off <= '0;
          r_wr     <= '0;
          r_rtrail <= 1'b0;
        end else begin
          r_row <= r_row + 1'b1;
          if (w_wr_end) begin
            r_wr_off <= '0;
            if (r_wr == c_wr_last) r_rtrail <= 1'b1;
            else                   r_wr     <= r_wr + 1'b1;
          end else begin
            r_wr_off <= r_wr_off + 1'b1;
          end
        end
      end else begin
        r_col <= r_col + 1'b1;
        if (w_wc_end) begin
          r_wc_off <= '0;
          if (r_wc == c_wc_last) r_ctrail <= 1'b1;
          else                   r_wc     <= r_wc + 1'b1;
        end else begin
          r_wc_off <= r_wc_off + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h     <= '0;
      for (int i = 0; i < OW; i++) r_p[i] <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_pool  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      if (i_in_valid) begin
        r_h <= w_h_nxt;
        if (w_wc_end && w_in_grid) r_p[r_wc] <= w_p_nxt;
        if (w_done) begin
          r_valid <= 1'b1;
          r_last  <= (r_wc == c_wc_last) && (r_wr == c_wr_last);
          r_pool  <= w_pool;
        end
      end
    end
  end

  assign o_ot_valid = r_valid;
  assign o_ot_last  = r_last;
  assign o_ot_pool  = r_pool;

endmodule

`default_nettype wire

// File: tb/tb_cnn_pool2d.sv
// ============================================================================
// Module      : tb_cnn_pool2d
// Description : Self-checking bench for cnn_pool2d (8x8x3 and 7x5x4 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cnn_pool2d;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        a_valid, a_mode, a_ot_valid, a_ot_last;
  logic [23:0] a_pix, a_pool;
  logic        b_valid, b_mode, b_ot_valid, b_ot_last;
  logic [31:0] b_pix, b_pool;

  cnn_pool2d #(.CI(3), .IF_BW(8), .IMG_W(8), .IMG_H(8), .POOL_K(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .i_in_valid(a_valid), .i_in_pixel(a_pix),
    .i_mode(a_mode), .o_ot_valid(a_ot_valid), .o_ot_pool(a_pool), .o_ot_last(a_ot_last)
  );

  cnn_pool2d #(.CI(4), .IF_BW(8), .IMG_W(7), .IMG_H(5), .POOL_K(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .i_in_valid(b_valid), .i_in_pixel(b_pix),
    .i_mode(b_mode), .o_ot_valid(b_ot_valid), .o_ot_pool(b_pool), .o_ot_last(b_ot_last)
  );

  typedef struct packed {
    logic [31:0] pool;
    logic        last;
    logic [31:0] stamp;
  } out_t;

  typedef struct {
    int val;
    bit last;
  } tbl_t;

  out_t exp_q0[$], cap_q0[$], exp_q1[$], cap_q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   w_of[2] = '{8, 7};
  int   h_of[2] = '{8, 5};
  int   nch[2]  = '{3, 4};
  int   npix[2] = '{0, 0};
  int   fr[2][8][8][4];
  bit   md[2][8][8];
  logic [31:0] dat[128];
  bit   dmode[128];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_ot_valid === 1'b1) cap_q0.push_back('{pool: {8'h00, a_pool}, last: a_ot_last, stamp: cyc});
    if (b_ot_valid === 1'b1) cap_q1.push_back('{pool: b_pool, last: b_ot_last, stamp: cyc});
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Reference: each accepted pixel is placed in a frame image; when it closes
  // a 2x2 window inside the full-window grid the expected output is formed.
  task automatic model_accept(int d, logic [31:0] pix, bit m, int stamp);
    int col, row, ow, oh, v, acc, mx;
    bit wm;
    out_t e;
    col = npix[d] % w_of[d];
    row = npix[d] / w_of[d];
    ow  = w_of[d] / 2;
    oh  = h_of[d] / 2;
    for (int ch = 0; ch < 4; ch++) fr[d][row][col][ch] = int'(pix[ch*8 +: 8]);
    md[d][row][col] = m;
    if (col % 2 == 1 && row % 2 == 1 && col < ow * 2 && row < oh * 2) begin
      wm = md[d][row-1][col-1];
`ifndef POOL_AVG_EN
      wm = 1'b0;
`endif
      e.pool = '0;
      for (int ch = 0; ch < nch[d]; ch++) begin
        acc = 0;
        mx  = 0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            v = fr[d][row-1+dr][col-1+dc][ch];
            acc += v;
            if (v > mx) mx = v;
          end
        e.pool[ch*8 +: 8] = wm ? 8'(acc / 4) : 8'(mx);
      end
      e.last  = (col / 2 == ow - 1) && (row / 2 == oh - 1);
      e.stamp = 32'(stamp);
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
    npix[d] = (npix[d] + 1) % (w_of[d] * h_of[d]);
  endtask

  task automatic step(int d, bit v, logic [31:0] pix, bit m);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (d == 0) begin
      a_valid = v; a_pix = pix[23:0]; a_mode = m;
    end else begin
      b_valid = v; b_pix = pix; b_mode = m;
    end
    if (v) model_accept(d, pix, m, cyc + 1);
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 1'b0, $urandom, 1'($urandom));
  endtask

  task automatic run(int d, int n, bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) step(d, 1'b0, $urandom, 1'($urandom));
      step(d, 1'b1, dat[i], dmode[i]);
    end
    idle(3);
  endtask

  task automatic check_q(int d, string tag);
    int ne, na;
    out_t e, a;
    ne = (d == 0) ? exp_q0.size() : exp_q1.size();
    na = (d == 0) ? cap_q0.size() : cap_q1.size();
    n_cmp++;
    if (ne != na) begin
      n_bad++;
      $display("FAIL %s count: got %0d want %0d", tag, na, ne);
    end
    for (int i = 0; i < ne && i < na; i++) begin
      e = (d == 0) ? exp_q0[i] : exp_q1[i];
      a = (d == 0) ? cap_q0[i] : cap_q1[i];
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s out[%0d]: got pool=%h last=%b cyc=%0d want pool=%h last=%b cyc=%0d",
                 tag, i, a.pool, a.last, a.stamp, e.pool, e.last, e.stamp);
      end
    end
    exp_q0.delete(); cap_q0.delete(); exp_q1.delete(); cap_q1.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    tbl_t tbl[16];
    logic [31:0] last_pool;
    tbl = '{'{9, 0}, '{11, 0}, '{13, 0}, '{15, 0}, '{25, 0}, '{27, 0}, '{29, 0}, '{31, 0},
            '{41, 0}, '{43, 0}, '{45, 0}, '{47, 0}, '{57, 0}, '{59, 0}, '{61, 0}, '{63, 1}};

    reset_n = 1'b0;
    a_valid = 1'b0; a_pix = '0; a_mode = 1'b0;
    b_valid = 1'b0; b_pix = '0; b_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_valid", a_ot_valid, 0);
    chk("rst_a_last", a_ot_last, 0);
    chk("rst_a_pool", a_pool, 0);
    chk("rst_b_pool", b_pool, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Ramp frame: value row*8+col on every channel, max mode.
    for (int i = 0; i < 64; i++) begin
      dat[i] = {4{8'(i)}};
      dmode[i] = 1'b0;
    end
    run(0, 64, 1'b0);
    chk("tbl_count", cap_q0.size(), 16);
    for (int i = 0; i < 16 && i < cap_q0.size(); i++) begin
      chk($sformatf("tbl_pool[%0d]", i), cap_q0[i].pool, {8'h00, {3{8'(tbl[i].val)}}});
      chk($sformatf("tbl_last[%0d]", i), cap_q0[i].last, tbl[i].last);
    end
    check_q(0, "ramp");

    // Two random back-to-back frames, random mode, continuous then gapped.
    for (int i = 0; i < 128; i++) begin
      dat[i] = $urandom;
      dmode[i] = 1'($urandom);
    end
    run(0, 128, 1'b0);
    check_q(0, "rand_cont");
    run(0, 128, 1'b1);
    last_pool = exp_q0[exp_q0.size()-1].pool;
    check_q(0, "rand_gap");
    idle(2);
    chk("pool_hold", {8'h00, a_pool}, last_pool);

    // Reset after 11 pixels of a high-valued frame, then a low-valued frame.
    for (int i = 0; i < 11; i++) step(0, 1'b1, {4{8'($urandom_range(200, 255))}}, 1'b0);
    step(0, 1'b0, 32'h0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_pool", a_pool, 0);
    chk("mid_rst_valid", a_ot_valid, 0);
    chk("mid_rst_last", a_ot_last, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    npix[0] = 0;
    check_q(0, "pre_rst");
    for (int i = 0; i < 64; i++) begin
      dat[i] = {4{8'($urandom_range(0, 99))}};
      dmode[i] = 1'($urandom);
    end
    run(0, 64, 1'b1);
    check_q(0, "post_rst");

`ifdef POOL_AVG_EN
    for (int i = 0; i < 64; i++) begin
      dat[i] = $urandom;
      dmode[i] = 1'b1;
    end
    dat[0][7:0] = 8'd10; dat[1][7:0] = 8'd20; dat[8][7:0] = 8'd30; dat[9][7:0] = 8'd41;
    run(0, 64, 1'b0);
    if (cap_q0.size() > 0) chk("avg_25", cap_q0[0].pool[7:0], 25);
    else chk("avg_25_present", cap_q0.size(), 16);
    check_q(0, "avg_rand");
    for (int i = 0; i < 64; i++) dat[i] = 32'hFFFF_FFFF;
    run(0, 64, 1'b0);
    if (cap_q0.size() > 0) chk("avg_255", cap_q0[0].pool, 32'h00FF_FFFF);
    else chk("avg_255_present", cap_q0.size(), 16);
    check_q(0, "avg_255");
`endif

    // 7x5 frames with 4 distinctly patterned channels.
    for (int i = 0; i < 70; i++) begin
      dat[i] = {8'($urandom),
                ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 127)),
                8'd0, 8'($urandom)};
      dmode[i] = 1'($urandom);
    end
    run(1, 35, 1'b0);
    check_q(1, "b_frame1");
    for (int i = 0; i < 35; i++) dat[i] = dat[i+35];
    run(1, 35, 1'b1);
    check_q(1, "b_frame2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
